seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the team's BCD-to-7-segment path: it watches a multiplexed, active-low 7-segment display bus (segment lines plus per-digit enables), recovers each digit's BCD value, and publishes a complete multi-digit frame. Typical uses are display loopback checking and capturing an external module's display in the FPGA fabric. Inputs may be asynchronous to `clk`; the block synchronizes and debounces them internally.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digits (1–8).
- `SETTLE_CYCLES`, default 3: consecutive identical samples required before a capture (≥1).
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `seg_in` input 7: segment lines, active-low; bit 6 = a … bit 0 = g.
- `an_in` input NUM_DIGITS: digit enables, active-low, one-hot when a digit is lit.
- `bcd_out` output 4*NUM_DIGITS: last published frame; digit k in bits [4k+3:4k]; digit NUM_DIGITS-1 is most significant.
- `digit_err` output NUM_DIGITS: per-digit invalid-pattern flags for the published frame.
- `frame_valid` output 1: one-cycle pulse when `bcd_out` updates.
- `frame_error` output 1: OR of `digit_err`, updated with `bcd_out`.
- `bin_out` output 4*NUM_DIGITS: binary value of the frame (only with `SEG7_DEC_BIN_EN`).
- `bin_valid` output 1: one-cycle pulse when `bin_out` updates (only with `SEG7_DEC_BIN_EN`).

## Operation
- Reset: all outputs 0; shadow digits 4'hF; `seen` mask 0; settle counter 0; FSM in COLLECT.
- Two-flop synchronizer on `{an_in, seg_in}`. The settle counter resets to 0 when the synced word changes and otherwise saturates.
- Capture happens once per stable period, in the cycle the counter reaches SETTLE_CYCLES, and only if the synced `an` has exactly one low bit k.
- `an` all-high (blanking) or more than one low bit: no capture. The counter still runs, but no capture fires.
- Decode on capture, using the table 7'b0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - Blank 7'b1111111 gives nibble F with no error.
  - Any other pattern gives nibble F and error flag set.
- Each capture writes shadow[k] and err[k] and sets seen[k]. Recapturing a digit before the frame completes overwrites it (latest wins).
- FSM:
  - COLLECT → PUBLISH when `seen` becomes all-ones.
  - PUBLISH, one cycle: copies shadow/err to `bcd_out`/`digit_err`, asserts `frame_valid`, clears `seen`.
  - Without the macro, PUBLISH → COLLECT. With it, PUBLISH → CONVERT.
- Collection never stops. A capture landing in the PUBLISH cycle belongs to the next frame: `seen` is cleared, then that bit is set.

## Timing
- Pin change to capture: 2 sync cycles + SETTLE_CYCLES cycles.
- Capture that completes the set at cycle C: `frame_valid`, `bcd_out`, `digit_err`, and `frame_error` are all registered at C+1.
- Glitches shorter than SETTLE_CYCLES samples are never captured.
- Reset mid-frame or mid-conversion discards partial state immediately (asynchronously); no pulse is emitted.

## Configuration
- Macro `SEG7_DEC_BIN_EN`.
- Defined: CONVERT state, NUM_DIGITS cycles, MSB digit first.
  - Each cycle computes acc = acc*10 + d, with blank/invalid nibbles counted as 0.
  - Afterwards `bin_out` is loaded and `bin_valid` pulses at P+NUM_DIGITS+1 (P = PUBLISH cycle); FSM returns to COLLECT.
  - A frame completing during CONVERT waits in COLLECT with `seen` full and publishes immediately after.
- Not defined: no CONVERT state and no accumulator; `bin_out` and `bin_valid` ports are absent.

## Test plan
- Normal frame: NUM_DIGITS=4, SETTLE=3; show digits 3..0 = "1","2","3","4", 8 cycles each → exactly one `frame_valid`, `bcd_out`=16'h1234, `frame_error`=0. With the macro, `bin_out`=16'h04D2 and `bin_valid` 5 cycles after `frame_valid`.
- Short glitch: pattern 7'b0000000 on digit 0 for 2 cycles between stable "4"s → digit 0 stays 4, no extra capture.
- Invalid pattern: 7'b0110110 on digit 1, others valid → `digit_err`=4'b0010, `frame_error`=1, nibble 1 = F.
- Illegal enables: `an_in`=4'b1100 held 20 cycles → no capture, no `frame_valid`.
- Reset mid-frame: assert `rst_n` low after digits 3 and 2 are captured → all outputs 0; a full four-digit scan is required before the next `frame_valid`.
- Blank digit: digit 3 blank, then 0, 0, 7 → `bcd_out`=16'hF007, `frame_error`=0, and with the macro `bin_out`=7.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers BCD frames from a multiplexed active-low 7-segment bus
// Optional binary conversion of each published frame is enabled by defining SEG7_DEC_BIN_EN.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    frame_error
`ifdef SEG7_DEC_BIN_EN
    ,
    output logic [4*NUM_DIGITS-1:0] bin_out,
    output logic                    bin_valid
`endif
);

    localparam int WW = NUM_DIGITS + 7;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(SETTLE_CYCLES - 1);

`ifdef SEG7_DEC_BIN_EN
    typedef enum logic [1:0] {ST_COLLECT, ST_PUBLISH, ST_CONVERT} state_t;
`else
    typedef enum logic [0:0] {ST_COLLECT, ST_PUBLISH} state_t;
`endif

    // Returns {error, nibble}; blank is a legal "no digit" and decodes to F without error.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b0000001: seg_decode = 5'h00;
            7'b1001111: seg_decode = 5'h01;
            7'b0010010: seg_decode = 5'h02;
            7'b0000110: seg_decode = 5'h03;
            7'b1001100: seg_decode = 5'h04;
            7'b0100100: seg_decode = 5'h05;
            7'b0100000: seg_decode = 5'h06;
            7'b0001111: seg_decode = 5'h07;
            7'b0000000: seg_decode = 5'h08;
            7'b0000100: seg_decode = 5'h09;
            7'b1111111: seg_decode = 5'h0F;
            default:    seg_decode = 5'h1F;
        endcase
    endfunction

    logic [WW-1:0]         sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] err_q, err_d, seen_q, seen_d;
    state_t                state_q, state_d;
    logic [DW-1:0]         bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0] derr_q, derr_d;
    logic                  fv_q, fv_d, ferr_q, ferr_d;

    logic [NUM_DIGITS-1:0] an_s;
    logic [6:0]            seg_s;
    logic                  changed, capture;
    int unsigned           low_cnt;
    logic [IW-1:0]         cap_idx;
    logic [NUM_DIGITS-1:0] cap_mask;
    logic [4:0]            dec;

`ifdef SEG7_DEC_BIN_EN
    logic [DW-1:0] acc_q, acc_d, bin_q, bin_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          bv_q, bv_d;
    logic [3:0]    conv_nib;
`endif

    always_comb begin
        sync1_d = {an_in, seg_in};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        an_s    = sync2_q[WW-1:7];
        seg_s   = sync2_q[6:0];
        changed = (sync2_q != prev_q);

        cnt_d = cnt_q;
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        low_cnt = 0;
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                low_cnt = low_cnt + 1;
                cap_idx = IW'(i);
            end
        end

        // Fires only on the cycle the counter steps onto SETTLE_CYCLES, so once per stable period.
        capture  = !changed && (cnt_q == CNT_PRE) && (low_cnt == 1);
        cap_mask = capture ? (NUM_DIGITS'(1) << cap_idx) : '0;
        dec      = seg_decode(seg_s);

        shadow_d = shadow_q;
        err_d    = err_q;
        if (capture) begin
            shadow_d[4*cap_idx +: 4] = dec[3:0];
            err_d[cap_idx]           = dec[4];
        end
    end

    always_comb begin
        state_d = state_q;
        seen_d  = seen_q | cap_mask;
        bcd_d   = bcd_q;
        derr_d  = derr_q;
        fv_d    = 1'b0;
        ferr_d  = ferr_q;
`ifdef SEG7_DEC_BIN_EN
        acc_d    = acc_q;
        idx_d    = idx_q;
        bin_d    = bin_q;
        bv_d     = 1'b0;
        conv_nib = bcd_q[4*idx_q +: 4];
`endif
        case (state_q)
            ST_COLLECT: begin
                // Outputs load on the completing edge so they are visible throughout PUBLISH.
                if (&seen_d) begin
                    state_d = ST_PUBLISH;
                    bcd_d   = shadow_d;
                    derr_d  = err_d;
                    ferr_d  = |err_d;
                    fv_d    = 1'b1;
                end
            end
            ST_PUBLISH: begin
                seen_d = cap_mask;
`ifdef SEG7_DEC_BIN_EN
                state_d = ST_CONVERT;
                acc_d   = '0;
                idx_d   = IW'(NUM_DIGITS - 1);
`else
                state_d = ST_COLLECT;
`endif
            end
`ifdef SEG7_DEC_BIN_EN
            ST_CONVERT: begin
                acc_d = acc_q * DW'(10) + ((conv_nib > 4'd9) ? DW'(0) : DW'(conv_nib));
                if (idx_q == '0) begin
                    bin_d   = acc_d;
                    bv_d    = 1'b1;
                    state_d = ST_COLLECT;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
`endif
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            shadow_q <= '1;
            err_q    <= '0;
            seen_q   <= '0;
            state_q  <= ST_COLLECT;
            bcd_q    <= '0;
            derr_q   <= '0;
            fv_q     <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef SEG7_DEC_BIN_EN
            acc_q    <= '0;
            idx_q    <= '0;
            bin_q    <= '0;
            bv_q     <= 1'b0;
`endif
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            seen_q   <= seen_d;
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            derr_q   <= derr_d;
            fv_q     <= fv_d;
            ferr_q   <= ferr_d;
`ifdef SEG7_DEC_BIN_EN
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            bin_q    <= bin_d;
            bv_q     <= bv_d;
`endif
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_err   = derr_q;
    assign frame_valid = fv_q;
    assign frame_error = ferr_q;
`ifdef SEG7_DEC_BIN_EN
    assign bin_out     = bin_q;
    assign bin_valid   = bv_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed and random scan sequences checked against a frame-level model
module tb_seg7_scan_decoder;
    localparam int N     = 4;
    localparam int S     = 3;
    localparam int LONG  = S + 5;
    localparam int SHORT = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     seg_in = 7'h7F;
    logic [N-1:0]   an_in = '1;
    logic [4*N-1:0] bcd_out;
    logic [N-1:0]   digit_err;
    logic           frame_valid, frame_error;
`ifdef SEG7_DEC_BIN_EN
    logic [4*N-1:0] bin_out;
    logic           bin_valid;
`endif

    seg7_scan_decoder #(.NUM_DIGITS(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
        .bcd_out(bcd_out), .digit_err(digit_err),
        .frame_valid(frame_valid), .frame_error(frame_error)
`ifdef SEG7_DEC_BIN_EN
        , .bin_out(bin_out), .bin_valid(bin_valid)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0, fv_count = 0, fv_cyc = 0, bv_count = 0, bv_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (frame_valid === 1'b1) begin
            fv_count++;
            fv_cyc = cyc;
        end
`ifdef SEG7_DEC_BIN_EN
        if (bin_valid === 1'b1) begin
            bv_count++;
            bv_cyc = cyc;
        end
`endif
    end

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    logic [3:0]       m_nib [N];
    logic             m_err [N];
    bit               m_seen [N];
    int               exp_count = 0;
    logic [4*N-1:0]   exp_bcd = '0;
    logic [N-1:0]     exp_err = '0;
    logic [N+6:0]     last_word = '1;

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int v = 0; v < 10; v++)
            if (seg_tab[v] == s) return {1'b0, 4'(v)};
        if (s == 7'h7F) return 5'h0F;
        return 5'h1F;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] dig(input int k);
        return ~(N'(1) << k);
    endfunction

    task automatic step(input logic [N-1:0] an, input logic [6:0] seg, input int hold);
        int k = 0, lows = 0;
        logic [4:0] d;
        bit full, frame = 0;
        int exp_bin;
        if ({an, seg} === last_word) begin
            an_in = '1;
            seg_in = 7'h7F;
            repeat (3) @(negedge clk);
        end
        an_in = an;
        seg_in = seg;
        last_word = {an, seg};
        repeat (hold) @(negedge clk);
        for (int i = 0; i < N; i++)
            if (!an[i]) begin
                lows++;
                k = i;
            end
        if (hold >= LONG && lows == 1) begin
            d = ref_decode(seg);
            m_nib[k] = d[3:0];
            m_err[k] = d[4];
            m_seen[k] = 1;
            full = 1;
            for (int i = 0; i < N; i++) full &= m_seen[i];
            if (full) begin
                frame = 1;
                exp_count++;
                for (int i = 0; i < N; i++) begin
                    exp_bcd[4*i +: 4] = m_nib[i];
                    exp_err[i] = m_err[i];
                    m_seen[i] = 0;
                end
            end
        end
        check("frame_count", 64'(fv_count), 64'(exp_count));
        if (frame) begin
            check("bcd_out", 64'(bcd_out), 64'(exp_bcd));
            check("digit_err", 64'(digit_err), 64'(exp_err));
            check("frame_error", 64'(frame_error), 64'(|exp_err));
`ifdef SEG7_DEC_BIN_EN
            exp_bin = 0;
            for (int i = 0; i < N; i++)
                exp_bin += ((m_nib[i] > 9) ? 0 : int'(m_nib[i])) * (10 ** i);
            repeat (N + 3) @(negedge clk);
            check("bin_count", 64'(bv_count), 64'(exp_count));
            check("bin_out", 64'(bin_out), 64'(exp_bin));
            check("bin_latency", 64'(bv_cyc - fv_cyc), 64'(N + 1));
`endif
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bcd"}, 64'(bcd_out), 64'h0);
        check({tag, "_err"}, 64'(digit_err), 64'h0);
        check({tag, "_fv"}, 64'(frame_valid), 64'h0);
        check({tag, "_ferr"}, 64'(frame_error), 64'h0);
`ifdef SEG7_DEC_BIN_EN
        check({tag, "_bin"}, 64'(bin_out), 64'h0);
        check({tag, "_bv"}, 64'(bin_valid), 64'h0);
`endif
    endtask

    task automatic do_reset();
        an_in = '1;
        seg_in = 7'h7F;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) m_seen[i] = 0;
        exp_bcd = '0;
        exp_err = '0;
        last_word = '1;
    endtask

    initial begin
        logic [6:0] s;
        logic [4:0] d;
        logic [N-1:0] a;
        int lows;
        for (int i = 0; i < N; i++) begin
            m_nib[i] = 4'hF;
            m_err[i] = 0;
            m_seen[i] = 0;
        end
        repeat (2) @(negedge clk);
        check_zero("por");
        rst_n = 1'b1;
        @(negedge clk);

        // normal frame "1234"
        step(dig(3), seg_tab[1], LONG);
        step(dig(2), seg_tab[2], LONG);
        step(dig(1), seg_tab[3], LONG);
        step(dig(0), seg_tab[4], LONG);

        // short all-segments glitch on digit 0 between stable 4s
        step(dig(0), seg_tab[4], LONG);
        step(dig(0), 7'b0000000, SHORT);
        step(dig(0), seg_tab[4], LONG);
        step(dig(3), seg_tab[1], LONG);
        step(dig(2), seg_tab[2], LONG);
        step(dig(1), seg_tab[3], LONG);

        // invalid pattern on digit 1
        step(dig(3), seg_tab[5], LONG);
        step(dig(2), seg_tab[6], LONG);
        step(dig(1), 7'b0110110, LONG);
        step(dig(0), seg_tab[7], LONG);

        // two digits enabled at once
        step(4'b1100, seg_tab[8], 20);

        // reset after two captures discards the partial frame
        step(dig(3), seg_tab[9], LONG);
        step(dig(2), seg_tab[8], LONG);
        do_reset();
        @(negedge clk);
        step(dig(1), seg_tab[1], LONG);
        step(dig(0), seg_tab[2], LONG);
        step(dig(3), seg_tab[3], LONG);
        step(dig(2), seg_tab[4], LONG);

        // blank leading digit
        step(dig(3), 7'h7F, LONG);
        step(dig(2), seg_tab[0], LONG);
        step(dig(1), seg_tab[0], LONG);
        step(dig(0), seg_tab[7], LONG);

        // random scan traffic
        for (int n = 0; n < 80; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 80) s = seg_tab[$urandom_range(0, 9)];
            else if (r < 90) s = 7'h7F;
            else begin
                s = 7'($urandom);
                d = ref_decode(s);
                while (d[4] == 1'b0) begin
                    s = 7'($urandom);
                    d = ref_decode(s);
                end
            end
            r = $urandom_range(0, 99);
            if (r < 10) begin
                a = N'($urandom);
                lows = 0;
                for (int i = 0; i < N; i++) if (!a[i]) lows++;
                if (lows == 1) a = '1;
                step(a, s, LONG);
            end else if (r < 25) begin
                step(dig($urandom_range(0, N - 1)), s, $urandom_range(1, SHORT));
            end else begin
                step(dig($urandom_range(0, N - 1)), s, LONG + $urandom_range(0, 4));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
